// File: rtl/compressor_scheduler_pkg.sv
// Shared types and constants for the compressor scheduler: sample width default,
// FSM state encoding and the channel-index width helper.
package compressor_scheduler_pkg;

    localparam int DW_DEFAULT = 16;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/compressor_scheduler_rr_arbiter.sv
// Round-robin picker: first pending channel at or after rr_ptr, wrapping at NUM_CH.
// Purely combinational; the caller registers the result.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [SEL_W-1:0]  rr_ptr,
    output logic              grant_valid,
    output logic [SEL_W-1:0]  grant_idx
);

    logic [SEL_W-1:0]  rot_idx [NUM_CH];
    logic [NUM_CH-1:0] cand;

    // Offset gi from the pointer, wrapped without a modulo so NUM_CH need not be a power of two.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
            logic [SEL_W:0] sum;
            assign sum         = {1'b0, rr_ptr} + (SEL_W+1)'(gi);
            assign rot_idx[gi] = (sum >= (SEL_W+1)'(NUM_CH)) ?
                                 SEL_W'(sum - (SEL_W+1)'(NUM_CH)) : sum[SEL_W-1:0];
            assign cand[gi]    = pending[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant_valid = |cand;
        grant_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                grant_idx = rot_idx[i];
            end
        end
    end

endmodule

// File: rtl/compressor_scheduler.sv
// Shares one registered compressor core across NUM_CH channels, round-robin.
// Optional build macro COMP_SCHED_STATS_EN adds per-channel saturating drop counters.
module compressor_scheduler
    import compressor_scheduler_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DW     = DW_DEFAULT,
    parameter int SEL_W  = sel_width(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    in_valid,
    input  logic [NUM_CH*DW-1:0] in_sample_flat,
    input  logic [NUM_CH-1:0]    ch_enable,
    input  logic [NUM_CH-1:0]    overrun_clr,
    output logic                 core_enable,
    output logic [DW-1:0]        core_in_sample,
    input  logic [DW-1:0]        core_out_sample,
    output logic [NUM_CH-1:0]    out_valid,
    output logic [NUM_CH*DW-1:0] out_sample_flat,
    output logic [NUM_CH-1:0]    overrun,
    output logic                 busy
`ifdef COMP_SCHED_STATS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] overrun_cnt_flat
`endif
);

    state_t            state_reg, state_next;
    logic [SEL_W-1:0]  rr_ptr_reg;
    logic [SEL_W-1:0]  sel_reg;
    logic [DW-1:0]     issue_reg;
    logic              en_reg;
    logic [NUM_CH-1:0] pending_vec;
    logic [DW-1:0]     buf_arr [NUM_CH];
    logic              grant_valid;
    logic [SEL_W-1:0]  grant_idx;
    logic              grant_fire;
    logic              capture_fire;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .pending     (pending_vec),
        .rr_ptr      (rr_ptr_reg),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = ISSUE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_fire   = (state_reg == IDLE) && grant_valid;
        capture_fire = (state_reg == CAPTURE);
        busy         = (state_reg != IDLE);
    end

    // The granted sample is copied out here, so a same-cycle refill of its buffer is harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_reg    <= '0;
            issue_reg  <= '0;
            en_reg     <= 1'b0;
            rr_ptr_reg <= '0;
        end else if (grant_fire) begin
            sel_reg    <= grant_idx;
            issue_reg  <= buf_arr[grant_idx];
            en_reg     <= ch_enable[grant_idx];
            rr_ptr_reg <= (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
    end

    assign core_in_sample = issue_reg;
    assign core_enable    = en_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic          granted;
            logic          drop;
            logic          pending_reg;
            logic          overrun_reg;
            logic          out_valid_reg;
            logic [DW-1:0] buf_reg;
            logic [DW-1:0] out_sample_reg;

            assign granted = grant_fire && (grant_idx == SEL_W'(gi));
            assign drop    = in_valid[gi] && pending_reg && !granted;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pending_reg    <= 1'b0;
                    overrun_reg    <= 1'b0;
                    out_valid_reg  <= 1'b0;
                    buf_reg        <= '0;
                    out_sample_reg <= '0;
                end else begin
                    if (in_valid[gi]) begin
                        buf_reg     <= in_sample_flat[gi*DW +: DW];
                        pending_reg <= 1'b1;
                    end else if (granted) begin
                        pending_reg <= 1'b0;
                    end
                    if (drop) begin
                        overrun_reg <= 1'b1;
                    end else if (overrun_clr[gi]) begin
                        overrun_reg <= 1'b0;
                    end
                    out_valid_reg <= capture_fire && (sel_reg == SEL_W'(gi));
                    if (capture_fire && (sel_reg == SEL_W'(gi))) begin
                        out_sample_reg <= core_out_sample;
                    end
                end
            end

            assign pending_vec[gi]                 = pending_reg;
            assign buf_arr[gi]                     = buf_reg;
            assign overrun[gi]                     = overrun_reg;
            assign out_valid[gi]                   = out_valid_reg;
            assign out_sample_flat[gi*DW +: DW]    = out_sample_reg;

`ifdef COMP_SCHED_STATS_EN
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (overrun_clr[gi]) begin
                    cnt_reg <= drop ? CNT_W'(1) : '0;
                end else if (drop && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
            assign overrun_cnt_flat[gi*CNT_W +: CNT_W] = cnt_reg;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_compressor_scheduler.sv
// Testbench for compressor_scheduler: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_compressor_scheduler;

    localparam int NUM_CH = 4;
    localparam int DW     = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_CH-1:0]    in_valid = '0;
    logic [NUM_CH*DW-1:0] in_sample_flat = '0;
    logic [NUM_CH-1:0]    ch_enable = '0;
    logic [NUM_CH-1:0]    overrun_clr = '0;
    logic                 core_enable;
    logic [DW-1:0]        core_in_sample;
    logic [DW-1:0]        core_out_sample;
    logic [NUM_CH-1:0]    out_valid;
    logic [NUM_CH*DW-1:0] out_sample_flat;
    logic [NUM_CH-1:0]    overrun;
    logic                 busy;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    always #5 clk = ~clk;

    compressor_scheduler #(.NUM_CH(NUM_CH), .DW(DW)) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_sample_flat  (in_sample_flat),
        .ch_enable       (ch_enable),
        .overrun_clr     (overrun_clr),
        .core_enable     (core_enable),
        .core_in_sample  (core_in_sample),
        .core_out_sample (core_out_sample),
        .out_valid       (out_valid),
        .out_sample_flat (out_sample_flat),
        .overrun         (overrun),
        .busy            (busy)
    );

    // Stand-in core: one register stage, halves the sample when enabled, passes it through otherwise.
    always @(posedge clk or posedge rst) begin
        if (rst) core_out_sample <= '0;
        else     core_out_sample <= core_enable ? DW'($signed(core_in_sample) >>> 1) : core_in_sample;
    end

    task automatic chk(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit       m_pend [NUM_CH];
    int       m_buf  [NUM_CH];
    bit       m_ovr  [NUM_CH];
    int       m_held [NUM_CH];
    int       m_rr, m_cnt, m_ch, m_val, m_in;
    bit       m_en;
    bit [3:0] m_valid;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_pend[c] = 0; m_buf[c] = 0; m_ovr[c] = 0; m_held[c] = 0;
        end
        m_rr = 0; m_cnt = 0; m_ch = 0; m_val = 0; m_in = 0; m_en = 0; m_valid = '0;
    endtask

    task automatic model_step();
        int g;
        g = -1;
        m_valid = '0;
        if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_valid[m_ch] = 1'b1;
                m_held[m_ch]  = m_val;
                $display("txn cycle %0d: ch%0d result %0d", cycle, m_ch, m_val);
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                int c;
                c = (m_rr + i) % NUM_CH;
                if (g < 0 && m_pend[c]) g = c;
            end
            if (g >= 0) begin
                m_ch      = g;
                m_en      = ch_enable[g];
                m_in      = m_buf[g];
                m_val     = m_en ? (m_in >>> 1) : m_in;
                m_pend[g] = 0;
                m_rr      = (g + 1) % NUM_CH;
                m_cnt     = 2;
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (in_valid[c] && m_pend[c]) m_ovr[c] = 1;
            else if (overrun_clr[c])      m_ovr[c] = 0;
            if (in_valid[c]) begin
                m_pend[c] = 1;
                m_buf[c]  = $signed(in_sample_flat[c*DW +: DW]);
            end
        end
    endtask

    task automatic model_compare();
        bit [3:0] ov;
        for (int c = 0; c < NUM_CH; c++) ov[c] = m_ovr[c];
        chk("out_valid", out_valid, m_valid);
        for (int c = 0; c < NUM_CH; c++)
            chk("out_sample", $signed(out_sample_flat[c*DW +: DW]), m_held[c]);
        chk("overrun", overrun, ov);
        chk("busy", busy, m_cnt > 0);
        if (m_cnt == 2) begin
            chk("core_enable", core_enable, m_en);
            chk("core_in_sample", $signed(core_in_sample), m_in);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            cycle++;
            if (rst) model_reset();
            else     model_step();
            #1;
            if (!rst) model_compare();
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed helpers ----------------
    function automatic logic [63:0] pack(input int s0, input int s1, input int s2, input int s3);
        return {16'(s3), 16'(s2), 16'(s1), 16'(s0)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = '0; overrun_clr = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input bit [3:0] mask, input logic [63:0] data);
        @(negedge clk);
        in_valid = mask; in_sample_flat = data;
        @(negedge clk);
        in_valid = '0;
    endtask

    task automatic wait_out(input int budget, output bit [3:0] mask, output int at);
        bit seen;
        seen = 0; mask = '0; at = -1;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #2;
            if (out_valid != '0) begin
                seen = 1; mask = out_valid; at = cycle;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL wait_out: no out_valid within %0d cycles, got none required one", budget);
        end
    endtask

    initial begin
        bit [3:0] m;
        int at, prev;
        bit [3:0] any_v;

        // Single channel, enabled
        do_reset();
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_core_enable", core_enable, 0);
        chk("rst_core_in", $signed(core_in_sample), 0);
        ch_enable = 4'hF;
        send(4'b0001, pack(12000, 0, 0, 0));
        @(posedge clk); #2;
        chk("t1_core_in", $signed(core_in_sample), 12000);
        chk("t1_core_enable", core_enable, 1);
        chk("t1_busy", busy, 1);
        @(posedge clk); #2;
        chk("t1_early_valid", out_valid, 0);
        @(posedge clk); #2;
        chk("t1_valid", out_valid, 4'b0001);
        chk("t1_out", $signed(out_sample_flat[15:0]), 6000);

        // All four at once: round-robin order, 3-cycle spacing, pointer wraps to 0
        do_reset();
        send(4'b1111, pack(100, 200, 300, 400));
        prev = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            wait_out(20, m, at);
            chk("t2_order", m, 1 << k);
            chk("t2_value", $signed(out_sample_flat[k*DW +: DW]), 50 * (k + 1));
            if (k > 0) chk("t2_gap", at - prev, 3);
            prev = at;
        end
        send(4'b1001, pack(7, 0, 0, 800));
        wait_out(20, m, at);
        chk("t2_wrap_first", m, 4'b0001);
        chk("t2_wrap_val0", $signed(out_sample_flat[15:0]), 3);
        wait_out(20, m, at);
        chk("t2_wrap_second", m, 4'b1000);
        chk("t2_wrap_val3", $signed(out_sample_flat[63:48]), 400);

        // Bypass channel
        do_reset();
        ch_enable = 4'b1011;
        send(4'b0100, pack(0, 0, -20000, 0));
        @(posedge clk); #2;
        chk("t3_core_enable", core_enable, 0);
        chk("t3_core_in", $signed(core_in_sample), -20000);
        wait_out(20, m, at);
        chk("t3_mask", m, 4'b0100);
        chk("t3_out", $signed(out_sample_flat[47:32]), -20000);
        ch_enable = 4'hF;

        // Overrun on ch1 while the core serves ch0
        do_reset();
        @(negedge clk); in_valid = 4'b0011; in_sample_flat = pack(10, 500, 0, 0);
        @(negedge clk); in_valid = 4'b0010; in_sample_flat = pack(0, 600, 0, 0);
        @(negedge clk); in_valid = '0;
        #1;
        chk("t4_overrun_set", overrun, 4'b0010);
        wait_out(20, m, at);
        chk("t4_first", m, 4'b0001);
        chk("t4_val0", $signed(out_sample_flat[15:0]), 5);
        wait_out(20, m, at);
        chk("t4_second", m, 4'b0010);
        chk("t4_val1", $signed(out_sample_flat[31:16]), 300);
        any_v = '0;
        repeat (8) begin @(posedge clk); #2; any_v |= out_valid; end
        chk("t4_no_extra", any_v, 0);
        @(negedge clk); overrun_clr = 4'b0010;
        @(negedge clk); overrun_clr = '0;
        #1;
        chk("t4_overrun_clr", overrun, 0);

        // New sample on ch0 in its own grant cycle
        do_reset();
        @(negedge clk); in_valid = 4'b0001; in_sample_flat = pack(1000, 0, 0, 0);
        @(negedge clk); in_valid = 4'b0001; in_sample_flat = pack(2000, 0, 0, 0);
        @(negedge clk); in_valid = '0;
        wait_out(20, m, at);
        chk("t5_first_val", $signed(out_sample_flat[15:0]), 500);
        prev = at;
        wait_out(20, m, at);
        chk("t5_second_mask", m, 4'b0001);
        chk("t5_second_val", $signed(out_sample_flat[15:0]), 1000);
        chk("t5_gap", at - prev, 3);
        chk("t5_overrun", overrun, 0);

        // Reset during CAPTURE
        do_reset();
        send(4'b0001, pack(4000, 0, 0, 0));
        wait_out(20, m, at);
        chk("t6_pre_val", $signed(out_sample_flat[15:0]), 2000);
        send(4'b0001, pack(4002, 0, 0, 0));
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_out", $signed(out_sample_flat[15:0]), 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_core_en", core_enable, 0);
        @(negedge clk); rst = 1'b0;
        any_v = '0;
        repeat (6) begin @(posedge clk); #2; any_v |= out_valid; end
        chk("t6_no_valid", any_v, 0);
        send(4'b0010, pack(0, 3000, 0, 0));
        wait_out(20, m, at);
        chk("t6_resume_mask", m, 4'b0010);
        chk("t6_resume_val", $signed(out_sample_flat[31:16]), 1500);

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                in_valid[c] = ($urandom_range(0, 9) == 0);
                in_sample_flat[c*DW +: DW] = 16'($urandom);
            end
            if ($urandom_range(0, 15) == 0) ch_enable = 4'($urandom);
            overrun_clr = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'b0;
        end
        @(negedge clk);
        in_valid = '0; overrun_clr = '0;
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
